// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks queued fetch predictions against execute outcomes, redirects on mispredict, and feeds predictor updates and statistics.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int TARGET_WIDTH = 32,
  parameter int ILEN_BYTES   = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    fetchValid_i,
  input  logic [TARGET_WIDTH-1:0] fetchPc_i,
  input  logic                    fetchHit_i,
  input  logic [TARGET_WIDTH-1:0] fetchTarget_i,
  output logic                    queueFull_o,
  input  logic                    resolveValid_i,
  input  logic                    resolveIsBranch_i,
  input  logic                    resolveTaken_i,
  input  logic [TARGET_WIDTH-1:0] resolveTarget_i,
  input  logic                    flush_i,
  output logic                    redirect_o,
  output logic [TARGET_WIDTH-1:0] redirectPc_o,
  output logic                    exValid_o,
  output logic                    exTaken_o,
  output logic [TARGET_WIDTH-1:0] exPc_o,
  output logic [TARGET_WIDTH-1:0] exTarget_o,
  output logic [CNT_WIDTH-1:0]    branchCount_o,
  output logic [CNT_WIDTH-1:0]    mispredCount_o,
  output logic                    protoErr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [TARGET_WIDTH-1:0] pc;
    logic                    tkn;
    logic [TARGET_WIDTH-1:0] tgt;
  } entry_t;
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t hd;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic redirect_q, redirect_d, ex_valid_q, ex_valid_d, ex_taken_q, ex_taken_d, proto_err_q, proto_err_d;
  logic [TARGET_WIDTH-1:0] redirect_pc_q, redirect_pc_d, ex_pc_q, ex_pc_d, ex_target_q, ex_target_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
  logic pop, push, act_t, mis, upd, drop_all;
  assign queueFull_o = count_q == CW'(DEPTH);
  always_comb begin
    hd = mem_q[head_q];
    pop = resolveValid_i & (count_q != '0);
    act_t = resolveIsBranch_i & resolveTaken_i;
    mis = pop & ((act_t != hd.tkn) | (act_t & hd.tkn & (resolveTarget_i != hd.tgt)));
    drop_all = mis | flush_i;
    push = fetchValid_i & ~drop_all & ~redirect_q & (~queueFull_o | pop);
    mem_d = mem_q;
    if (push) mem_d[tail_q] = '{pc: fetchPc_i, tkn: fetchHit_i, tgt: fetchTarget_i};
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = drop_all ? head_d : (push ? tail_q + 1'b1 : tail_q);
    count_d = drop_all ? '0 : count_q + CW'(push) - CW'(pop);
    upd = pop & (resolveIsBranch_i | hd.tkn);
    redirect_d = mis & ~flush_i;
    redirect_pc_d = redirect_d ? (act_t ? resolveTarget_i : hd.pc + TARGET_WIDTH'(ILEN_BYTES)) : redirect_pc_q;
    ex_valid_d = upd;
    ex_taken_d = upd & act_t;
    ex_pc_d = upd ? hd.pc : ex_pc_q;
    ex_target_d = upd ? resolveTarget_i : ex_target_q;
    branch_cnt_d = branch_cnt_q + CNT_WIDTH'(pop & resolveIsBranch_i & ~&branch_cnt_q);
    mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(mis & ~&mispred_cnt_q);
    proto_err_d = proto_err_q | (resolveValid_i & (count_q == '0));
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      ex_valid_q    <= 1'b0;
      ex_taken_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_target_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_taken_q    <= ex_taken_d;
      ex_pc_q       <= ex_pc_d;
      ex_target_q   <= ex_target_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      proto_err_q   <= proto_err_d;
    end
  end
  assign redirect_o     = redirect_q;
  assign redirectPc_o   = redirect_pc_q;
  assign exValid_o      = ex_valid_q;
  assign exTaken_o      = ex_taken_q;
  assign exPc_o         = ex_pc_q;
  assign exTarget_o     = ex_target_q;
  assign branchCount_o  = branch_cnt_q;
  assign mispredCount_o = mispred_cnt_q;
  assign protoErr_o     = proto_err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven directed vectors plus a mid-stream async reset sequence; 4-bit counters expose saturation.
module tb_branch_resolve_unit;
  logic clk_i = 1'b0;
  logic rstn_i;
  logic fetchValid_i, fetchHit_i, resolveValid_i, resolveIsBranch_i, resolveTaken_i, flush_i;
  logic [31:0] fetchPc_i, fetchTarget_i, resolveTarget_i;
  logic queueFull_o, redirect_o, exValid_o, exTaken_o, protoErr_o;
  logic [31:0] redirectPc_o, exPc_o, exTarget_o;
  logic [3:0] branchCount_o, mispredCount_o;
  int n_pass = 0;
  int n_total = 0;
  branch_resolve_unit #(.DEPTH(4), .TARGET_WIDTH(32), .ILEN_BYTES(4), .CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .fetchValid_i(fetchValid_i), .fetchPc_i(fetchPc_i), .fetchHit_i(fetchHit_i), .fetchTarget_i(fetchTarget_i),
    .queueFull_o(queueFull_o),
    .resolveValid_i(resolveValid_i), .resolveIsBranch_i(resolveIsBranch_i), .resolveTaken_i(resolveTaken_i),
    .resolveTarget_i(resolveTarget_i), .flush_i(flush_i),
    .redirect_o(redirect_o), .redirectPc_o(redirectPc_o),
    .exValid_o(exValid_o), .exTaken_o(exTaken_o), .exPc_o(exPc_o), .exTarget_o(exTarget_o),
    .branchCount_o(branchCount_o), .mispredCount_o(mispredCount_o), .protoErr_o(protoErr_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic fv; logic [31:0] fpc; logic fhit; logic [31:0] ftgt;
    logic rv, rb, rt; logic [31:0] rtgt; logic fl;
    logic red; logic [31:0] rpc; logic exv, ext; logic [31:0] expc, extgt;
    int bc, mc; logic perr, full;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(
    logic fv, logic [31:0] fpc, logic fhit, logic [31:0] ftgt,
    logic rv, logic rb, logic rt, logic [31:0] rtgt, logic fl,
    logic red, logic [31:0] rpc, logic exv, logic ext, logic [31:0] expc, logic [31:0] extgt,
    int bc, int mc, logic perr, logic full);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.fhit = fhit; v.ftgt = ftgt;
    v.rv = rv; v.rb = rb; v.rt = rt; v.rtgt = rtgt; v.fl = fl;
    v.red = red; v.rpc = rpc; v.exv = exv; v.ext = ext; v.expc = expc; v.extgt = extgt;
    v.bc = bc; v.mc = mc; v.perr = perr; v.full = full;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic drive(input logic fv, input logic [31:0] fpc, input logic fhit, input logic [31:0] ftgt,
                       input logic rv, input logic rb, input logic rt, input logic [31:0] rtgt, input logic fl);
    fetchValid_i = fv; fetchPc_i = fpc; fetchHit_i = fhit; fetchTarget_i = ftgt;
    resolveValid_i = rv; resolveIsBranch_i = rb; resolveTaken_i = rt; resolveTarget_i = rtgt; flush_i = fl;
  endtask
  initial begin
    logic [31:0] pops [10];
    pops = '{32'h14, 32'h18, 32'h1c, 32'h24, 32'h28, 32'h2c, 32'h30, 32'h34, 32'h38, 32'h3c};
    rstn_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // correct taken prediction
    tv.push_back(mk(1, 'h100, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h200, 0, 0, 0, 1, 1, 'h100, 'h200, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // direction mispredict discards younger entries; push in redirect cycle is dropped
    tv.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h300, 0, 1, 'h300, 1, 1, 'h100, 'h300, 2, 1, 0, 0));
    tv.push_back(mk(1, 'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tv.push_back(mk(1, 'h300, 1, 'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h400, 0, 0, 0, 1, 1, 'h300, 'h400, 3, 1, 0, 0));
    // aliased hit on a non-branch
    tv.push_back(mk(1, 'h40, 1, 'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 'h44, 1, 0, 'h40, 0, 3, 2, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0));
    // fill, overflow drop, pop+push at full, wrap
    tv.push_back(mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0));
    tv.push_back(mk(1, 'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0));
    tv.push_back(mk(1, 'h18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0));
    tv.push_back(mk(1, 'h1c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 1));
    tv.push_back(mk(1, 'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 1));
    tv.push_back(mk(1, 'h24, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 'h10, 0, 4, 2, 0, 1));
    for (int k = 0; k < 10; k++)
      tv.push_back(mk(1, 32'h28 + 32'(4 * k), 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, pops[k], 0, 5 + k, 2, 0, 1));
    // external flush with mispredicting pop, then resolve while empty
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h900, 1, 0, 0, 1, 1, 'h40, 'h900, 15, 3, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 3, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 3, 1, 0));
    // saturated branch counter holds
    tv.push_back(mk(1, 'h60, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 3, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 'h60, 0, 15, 3, 1, 0));
    tv.push_back(mk(1, 'h70, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 3, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h74, 0, 1, 'h74, 1, 1, 'h70, 'h74, 15, 4, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 4, 1, 0));
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset redirect", redirect_o, 0);
    chk("reset exValid", exValid_o, 0);
    chk("reset full", queueFull_o, 0);
    chk("reset branchCount", branchCount_o, 0);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    foreach (tv[i]) begin
      drive(tv[i].fv, tv[i].fpc, tv[i].fhit, tv[i].ftgt, tv[i].rv, tv[i].rb, tv[i].rt, tv[i].rtgt, tv[i].fl);
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d redirect", i), redirect_o, tv[i].red);
      if (tv[i].red) chk($sformatf("v%0d redirectPc", i), redirectPc_o, tv[i].rpc);
      chk($sformatf("v%0d exValid", i), exValid_o, tv[i].exv);
      chk($sformatf("v%0d exTaken", i), exTaken_o, tv[i].ext);
      if (tv[i].exv) begin
        chk($sformatf("v%0d exPc", i), exPc_o, tv[i].expc);
        chk($sformatf("v%0d exTarget", i), exTarget_o, tv[i].extgt);
      end
      chk($sformatf("v%0d branchCount", i), branchCount_o, 64'(tv[i].bc));
      chk($sformatf("v%0d mispredCount", i), mispredCount_o, 64'(tv[i].mc));
      chk($sformatf("v%0d protoErr", i), protoErr_o, tv[i].perr);
      chk($sformatf("v%0d full", i), queueFull_o, tv[i].full);
    end
    // mid-stream async reset with 3 entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h10 + 32'(4 * k), 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i);
      #1;
    end
    drive(1, 'h1c, 0, 0, 1, 1, 1, 'h55, 0);
    #2 rstn_i = 1'b0;
    #1;
    chk("async redirectPc", redirectPc_o, 0);
    chk("async exValid", exValid_o, 0);
    chk("async exPc", exPc_o, 0);
    chk("async exTarget", exTarget_o, 0);
    chk("async branchCount", branchCount_o, 0);
    chk("async mispredCount", mispredCount_o, 0);
    chk("async protoErr", protoErr_o, 0);
    chk("async full", queueFull_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("post-reset empty protoErr", protoErr_o, 1);
    chk("post-reset empty exValid", exValid_o, 0);
    chk("post-reset branchCount", branchCount_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
